// File: rtl/calc2_req_sched_pkg.sv
// Shared sizes, command/response encodings and queue entry type for the calc2 request scheduler.
package calc2_sched_pkg;
   localparam int NPORTS = 4;
   localparam int DW     = 32;
   localparam int TW     = 2;
   localparam int QDEPTH = 4;
   localparam int PW     = $clog2(NPORTS);
   localparam int QAW    = $clog2(QDEPTH);

   localparam logic [3:0] CMD_ADD = 4'h1;
   localparam logic [3:0] CMD_SUB = 4'h2;
   localparam logic [3:0] CMD_SHL = 4'h5;
   localparam logic [3:0] CMD_SHR = 4'h6;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_OK   = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b10;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
      logic [TW-1:0] tag;
   } req_entry_t;

   function automatic logic is_legal_cmd(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction
endpackage

// File: rtl/calc2_req_sched_if.sv
// Issue and response bus between the request scheduler (master) and the shared calc2 ALU (slave).
interface calc2_req_sched_if;
   import calc2_sched_pkg::*;

   logic          alu_valid;
   logic          alu_ready;
   logic [3:0]    alu_cmd;
   logic [DW-1:0] alu_op1;
   logic [DW-1:0] alu_op2;
   logic [PW-1:0] alu_port;
   logic [TW-1:0] alu_tag;
   logic          rsp_valid;
   logic [1:0]    rsp_resp;
   logic [DW-1:0] rsp_data;
   logic [PW-1:0] rsp_port;
   logic [TW-1:0] rsp_tag;

   modport master (
      output alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
      input  alu_ready, rsp_valid, rsp_resp, rsp_data, rsp_port, rsp_tag
   );

   modport slave (
      input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
      output alu_ready, rsp_valid, rsp_resp, rsp_data, rsp_port, rsp_tag
   );
endinterface

// File: rtl/calc2_req_sched_queue.sv
// Per-port two-cycle command collector feeding a small FIFO with registered full flag and sticky overflow.
//  state  | meaning
//  C_IDLE | waiting for cmd!=0; latches cmd, op1, tag
//  C_OP2  | current data is op2; pushes the assembled entry
module calc2_req_queue
   import calc2_sched_pkg::*;
(
   input  logic          c_clk,
   input  logic          reset,
   input  logic [3:0]    cmd_in,
   input  logic [DW-1:0] data_in,
   input  logic [TW-1:0] tag_in,
   input  logic          pop,
   output req_entry_t    head,
   output logic          empty,
   output logic          full,
   output logic          ovf
);
   typedef enum logic {C_IDLE, C_OP2} coll_state_t;

   localparam logic [QAW:0]   CNT_FULL   = (QAW+1)'(QDEPTH);
   localparam logic [QAW:0]   CNT_ALMOST = (QAW+1)'(QDEPTH-1);
   localparam logic [QAW:0]   CNT_ONE    = (QAW+1)'(1);
   localparam logic [QAW-1:0] PTR_ONE    = QAW'(1);

   coll_state_t   state;
   logic [3:0]    cmd_q;
   logic [DW-1:0] op1_q;
   logic [TW-1:0] tag_q;
   req_entry_t    mem [QDEPTH];
   logic [QAW-1:0] wr_ptr, rd_ptr;
   logic [QAW:0]  count, count_nxt;
   logic          push_req, do_push, do_pop, op2_nxt;

   assign empty    = (count == '0);
   assign head     = mem[rd_ptr];
   assign push_req = (state == C_OP2);
   assign do_push  = push_req && (count != CNT_FULL);
   assign do_pop   = pop && !empty;
   assign op2_nxt  = (state == C_IDLE) && (cmd_in != 4'h0);

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CNT_ONE;
      else if (!do_push && do_pop)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state  <= C_IDLE;
         cmd_q  <= '0;
         op1_q  <= '0;
         tag_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (state == C_IDLE) begin
            if (cmd_in != 4'h0) begin
               state <= C_OP2;
               cmd_q <= cmd_in;
               op1_q <= data_in;
               tag_q <= tag_in;
            end
         end else begin
            state <= C_IDLE;
         end
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (push_req && !do_push)
            ovf <= 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         // Look one push ahead so a requester mid-command sees full before its entry lands.
         full  <= (count_nxt == CNT_FULL) || ((count_nxt == CNT_ALMOST) && op2_nxt);
      end
   end

   always_ff @(posedge c_clk) begin
      if (do_push)
         mem[wr_ptr] <= '{cmd: cmd_q, op1: op1_q, op2: data_in, tag: tag_q};
   end
endmodule

// File: rtl/calc2_req_sched.sv
// Round-robin scheduler of four requester queues onto one calc2 ALU, with local illegal-command replies and response routing.
module calc2_req_sched
   import calc2_sched_pkg::*;
(
   input  logic                     c_clk,
   input  logic                     reset,
   input  logic [NPORTS-1:0][3:0]   req_cmd_in,
   input  logic [NPORTS-1:0][DW-1:0] req_data_in,
   input  logic [NPORTS-1:0][TW-1:0] req_tag_in,
   output logic [NPORTS-1:0]        req_full,
   output logic [NPORTS-1:0]        ovf_err,
   output logic [NPORTS-1:0][1:0]   out_resp,
   output logic [NPORTS-1:0][DW-1:0] out_data,
   output logic [NPORTS-1:0][TW-1:0] out_tag,
   calc2_req_sched_if.master        alu
);
   localparam logic [PW-1:0] PORT_ONE = PW'(1);

   req_entry_t        head [NPORTS];
   logic [NPORTS-1:0] q_empty, pop, cand, ill_pop, issue_pop, rsp_hit;
   logic              hold, handshake, grant_found;
   logic [PW-1:0]     rr_ptr, start, grant_port, idx;

   assign hold      = alu.alu_valid && !alu.alu_ready;
   assign handshake = alu.alu_valid && alu.alu_ready;
   assign start     = handshake ? alu.alu_port + PORT_ONE : rr_ptr;

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      calc2_req_queue u_queue (
         .c_clk   (c_clk),
         .reset   (reset),
         .cmd_in  (req_cmd_in[p]),
         .data_in (req_data_in[p]),
         .tag_in  (req_tag_in[p]),
         .pop     (pop[p]),
         .head    (head[p]),
         .empty   (q_empty[p]),
         .full    (req_full[p]),
         .ovf     (ovf_err[p])
      );
      assign rsp_hit[p]   = alu.rsp_valid && (alu.rsp_port == PW'(p));
      assign issue_pop[p] = handshake && (alu.alu_port == PW'(p));
      // The entry being accepted this cycle is still at the head, so it must not compete again.
      assign cand[p]      = !q_empty[p] && is_legal_cmd(head[p].cmd) && !issue_pop[p];
      assign ill_pop[p]   = !q_empty[p] && !is_legal_cmd(head[p].cmd) && !rsp_hit[p];
      assign pop[p]       = issue_pop[p] || ill_pop[p];
   end

   always_comb begin
      grant_found = 1'b0;
      grant_port  = '0;
      idx         = '0;
      for (int i = 0; i < NPORTS; i++) begin
         idx = start + PW'(i);
         if (!grant_found && cand[idx]) begin
            grant_found = 1'b1;
            grant_port  = idx;
         end
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         alu.alu_valid <= 1'b0;
         alu.alu_cmd   <= '0;
         alu.alu_op1   <= '0;
         alu.alu_op2   <= '0;
         alu.alu_port  <= '0;
         alu.alu_tag   <= '0;
         rr_ptr        <= '0;
         out_resp      <= '0;
         out_data      <= '0;
         out_tag       <= '0;
      end else begin
         if (!hold && grant_found) begin
            alu.alu_valid <= 1'b1;
            alu.alu_cmd   <= head[grant_port].cmd;
            alu.alu_op1   <= head[grant_port].op1;
            alu.alu_op2   <= head[grant_port].op2;
            alu.alu_port  <= grant_port;
            alu.alu_tag   <= head[grant_port].tag;
         end else if (handshake) begin
            alu.alu_valid <= 1'b0;
         end
         if (handshake)
            rr_ptr <= alu.alu_port + PORT_ONE;
         for (int p = 0; p < NPORTS; p++) begin
            if (rsp_hit[p]) begin
               out_resp[p] <= alu.rsp_resp;
               out_data[p] <= alu.rsp_data;
               out_tag[p]  <= alu.rsp_tag;
            end else if (ill_pop[p]) begin
               out_resp[p] <= RESP_ERR;
               out_data[p] <= '0;
               out_tag[p]  <= head[p].tag;
            end else begin
               out_resp[p] <= RESP_NONE;
               out_data[p] <= '0;
               out_tag[p]  <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_calc2_req_sched.sv
// Directed bench for calc2_req_sched: issue path, round-robin order, illegal replies, full/overflow, reset and routing.
module tb_calc2_req_sched;
   logic             c_clk = 1'b0;
   logic             reset = 1'b1;
   logic [3:0][3:0]  req_cmd_in;
   logic [3:0][31:0] req_data_in;
   logic [3:0][1:0]  req_tag_in;
   logic [3:0]       req_full;
   logic [3:0]       ovf_err;
   logic [3:0][1:0]  out_resp;
   logic [3:0][31:0] out_data;
   logic [3:0][1:0]  out_tag;
   int               n_checks = 0;
   int               n_fail = 0;

   calc2_req_sched_if alu_bus ();

   calc2_req_sched dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .req_full    (req_full),
      .ovf_err     (ovf_err),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .alu         (alu_bus)
   );

   always #5 c_clk = ~c_clk;

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic send_cmd(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [1:0] tag);
      req_cmd_in[p]  = cmd;
      req_data_in[p] = op1;
      req_tag_in[p]  = tag;
      tick();
      req_cmd_in[p]  = 4'h0;
      req_data_in[p] = op2;
      req_tag_in[p]  = 2'd0;
      tick();
      req_data_in[p] = 32'd0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %0b want 0", alu_bus.alu_valid); end
      n_checks++; if (alu_bus.alu_op1 !== 32'd0) begin n_fail++; $display("FAIL reset_alu_op1: got %h want 0", alu_bus.alu_op1); end
      n_checks++; if (req_full !== 4'b0) begin n_fail++; $display("FAIL reset_req_full: got %b want 0000", req_full); end
      n_checks++; if (ovf_err !== 4'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b want 0000", ovf_err); end
      n_checks++; if (out_resp !== 8'h00) begin n_fail++; $display("FAIL reset_out_resp: got %h want 00", out_resp); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      alu_bus.alu_ready = 1'b1;
      send_cmd(0, 4'h1, 32'd5, 32'd3, 2'd2);
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %0b want 0", alu_bus.alu_valid); end
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", alu_bus.alu_valid); end
      n_checks++; if (alu_bus.alu_cmd !== 4'h1) begin n_fail++; $display("FAIL basic_cmd: got %h want 1", alu_bus.alu_cmd); end
      n_checks++; if (alu_bus.alu_op1 !== 32'd5) begin n_fail++; $display("FAIL basic_op1: got %0d want 5", alu_bus.alu_op1); end
      n_checks++; if (alu_bus.alu_op2 !== 32'd3) begin n_fail++; $display("FAIL basic_op2: got %0d want 3", alu_bus.alu_op2); end
      n_checks++; if (alu_bus.alu_port !== 2'd0) begin n_fail++; $display("FAIL basic_port: got %0d want 0", alu_bus.alu_port); end
      n_checks++; if (alu_bus.alu_tag !== 2'd2) begin n_fail++; $display("FAIL basic_tag: got %0d want 2", alu_bus.alu_tag); end
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b want 0", alu_bus.alu_valid); end
      alu_bus.rsp_valid = 1'b1; alu_bus.rsp_port = 2'd0; alu_bus.rsp_resp = 2'b01;
      alu_bus.rsp_data = 32'd8; alu_bus.rsp_tag = 2'd2;
      tick();
      alu_bus.rsp_valid = 1'b0; alu_bus.rsp_data = 32'd0; alu_bus.rsp_resp = 2'b00; alu_bus.rsp_tag = 2'd0;
      n_checks++; if (out_resp[0] !== 2'b01) begin n_fail++; $display("FAIL basic_resp: got %b want 01", out_resp[0]); end
      n_checks++; if (out_data[0] !== 32'd8) begin n_fail++; $display("FAIL basic_data: got %0d want 8", out_data[0]); end
      n_checks++; if (out_tag[0] !== 2'd2) begin n_fail++; $display("FAIL basic_rsp_tag: got %0d want 2", out_tag[0]); end
      n_checks++; if (out_resp[3:1] !== 6'b0) begin n_fail++; $display("FAIL basic_other_resp: got %h want 0", out_resp[3:1]); end
      tick();
      n_checks++; if (out_resp[0] !== 2'b00) begin n_fail++; $display("FAIL basic_resp_pulse: got %b want 00", out_resp[0]); end
   endtask

   task automatic test_round(input logic [1:0] first, input string name);
      logic [1:0] exp_port;
      alu_bus.alu_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[p] = 4'h2; req_data_in[p] = 32'(10 + p); req_tag_in[p] = 2'(p);
      end
      tick();
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[p] = 4'h0; req_data_in[p] = 32'(20 + p); req_tag_in[p] = 2'd0;
      end
      tick();
      req_data_in = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_port = first + 2'(i);
         n_checks++; if (alu_bus.alu_valid !== 1'b1 || alu_bus.alu_port !== exp_port) begin
            n_fail++; $display("FAIL %s_grant%0d: got valid=%0b port=%0d want valid=1 port=%0d", name, i, alu_bus.alu_valid, alu_bus.alu_port, exp_port);
         end
         n_checks++; if (alu_bus.alu_op1 !== 32'(10 + int'(exp_port)) || alu_bus.alu_op2 !== 32'(20 + int'(exp_port))) begin
            n_fail++; $display("FAIL %s_ops%0d: got %0d/%0d want %0d/%0d", name, i, alu_bus.alu_op1, alu_bus.alu_op2, 10 + int'(exp_port), 20 + int'(exp_port));
         end
      end
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got %0b want 0", name, alu_bus.alu_valid); end
   endtask

   task automatic test_rr();
      test_round(2'd1, "rr_ptr1");
      send_cmd(3, 4'h5, 32'd1, 32'd1, 2'd0);
      tick();
      n_checks++; if (alu_bus.alu_port !== 2'd3) begin n_fail++; $display("FAIL rr_single_port: got %0d want 3", alu_bus.alu_port); end
      tick();
      test_round(2'd0, "rr_ptr0");
   endtask

   task automatic test_illegal();
      send_cmd(2, 4'h9, 32'd44, 32'd55, 2'd1);
      tick();
      n_checks++; if (out_resp[2] !== 2'b10) begin n_fail++; $display("FAIL illegal_resp: got %b want 10", out_resp[2]); end
      n_checks++; if (out_data[2] !== 32'd0) begin n_fail++; $display("FAIL illegal_data: got %h want 0", out_data[2]); end
      n_checks++; if (out_tag[2] !== 2'd1) begin n_fail++; $display("FAIL illegal_tag: got %0d want 1", out_tag[2]); end
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_no_issue: got %0b want 0", alu_bus.alu_valid); end
      tick();
      n_checks++; if (out_resp[2] !== 2'b00) begin n_fail++; $display("FAIL illegal_pulse: got %b want 00", out_resp[2]); end
      send_cmd(2, 4'hB, 32'd0, 32'd0, 2'd3);
      alu_bus.rsp_valid = 1'b1; alu_bus.rsp_port = 2'd2; alu_bus.rsp_resp = 2'b01;
      alu_bus.rsp_data = 32'h77; alu_bus.rsp_tag = 2'd0;
      tick();
      alu_bus.rsp_valid = 1'b0; alu_bus.rsp_data = 32'd0; alu_bus.rsp_resp = 2'b00;
      n_checks++; if (out_resp[2] !== 2'b01 || out_data[2] !== 32'h77) begin n_fail++; $display("FAIL collide_alu_wins: got %b/%h want 01/77", out_resp[2], out_data[2]); end
      tick();
      n_checks++; if (out_resp[2] !== 2'b10 || out_tag[2] !== 2'd3) begin n_fail++; $display("FAIL collide_retry: got %b tag %0d want 10 tag 3", out_resp[2], out_tag[2]); end
      tick();
      n_checks++; if (out_resp[2] !== 2'b00) begin n_fail++; $display("FAIL collide_once: got %b want 00", out_resp[2]); end
   endtask

   task automatic test_full_ovf();
      alu_bus.alu_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_cmd(1, 4'h1, 32'(100 + k), 32'(200 + k), 2'(k));
         if (k == 2) begin
            n_checks++; if (req_full[1] !== 1'b0) begin n_fail++; $display("FAIL full_after3: got %0b want 0", req_full[1]); end
         end
         if (k == 3) begin
            n_checks++; if (req_full[1] !== 1'b1) begin n_fail++; $display("FAIL full_after4: got %0b want 1", req_full[1]); end
            n_checks++; if (ovf_err[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b want 0", ovf_err[1]); end
         end
         if (k >= 1) begin
            n_checks++; if (alu_bus.alu_valid !== 1'b1 || alu_bus.alu_op1 !== 32'd100 || alu_bus.alu_op2 !== 32'd200 || alu_bus.alu_port !== 2'd1) begin
               n_fail++; $display("FAIL hold_stable%0d: got v=%0b op1=%0d op2=%0d port=%0d want 1/100/200/1", k, alu_bus.alu_valid, alu_bus.alu_op1, alu_bus.alu_op2, alu_bus.alu_port);
            end
         end
      end
      n_checks++; if (ovf_err !== 4'b0010) begin n_fail++; $display("FAIL ovf_set: got %b want 0010", ovf_err); end
      alu_bus.alu_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      n_checks++; if (req_full[1] !== 1'b0 || alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL drain: got full=%0b valid=%0b want 0/0", req_full[1], alu_bus.alu_valid); end
      n_checks++; if (ovf_err[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", ovf_err[1]); end
   endtask

   task automatic test_reset_mid();
      alu_bus.alu_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_cmd(0, 4'h2, 32'(50 + k), 32'd1, 2'd0);
      n_checks++; if (alu_bus.alu_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b want 1", alu_bus.alu_valid); end
      reset = 1'b1;
      #1;
      n_checks++; if (alu_bus.alu_valid !== 1'b0 || alu_bus.alu_op1 !== 32'd0 || alu_bus.alu_cmd !== 4'h0) begin
         n_fail++; $display("FAIL mid_alu_clear: got v=%0b op1=%0d cmd=%0d want 0/0/0", alu_bus.alu_valid, alu_bus.alu_op1, alu_bus.alu_cmd);
      end
      n_checks++; if (ovf_err !== 4'b0 || req_full !== 4'b0) begin n_fail++; $display("FAIL mid_flags_clear: got ovf=%b full=%b want 0/0", ovf_err, req_full); end
      tick();
      reset = 1'b0;
      alu_bus.alu_ready = 1'b1;
      send_cmd(3, 4'h5, 32'd7, 32'd2, 2'd3);
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b1 || alu_bus.alu_port !== 2'd3 || alu_bus.alu_cmd !== 4'h5 || alu_bus.alu_op1 !== 32'd7) begin
         n_fail++; $display("FAIL mid_first_issue: got v=%0b port=%0d cmd=%0d op1=%0d want 1/3/5/7", alu_bus.alu_valid, alu_bus.alu_port, alu_bus.alu_cmd, alu_bus.alu_op1);
      end
      tick();
      n_checks++; if (alu_bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL mid_queues_empty: got %0b want 0", alu_bus.alu_valid); end
   endtask

   task automatic test_rsp_route();
      alu_bus.rsp_valid = 1'b1; alu_bus.rsp_port = 2'd3; alu_bus.rsp_resp = 2'b10;
      alu_bus.rsp_data = 32'd0; alu_bus.rsp_tag = 2'd2;
      tick();
      alu_bus.rsp_valid = 1'b0; alu_bus.rsp_resp = 2'b00; alu_bus.rsp_tag = 2'd0;
      n_checks++; if (out_resp[3] !== 2'b10 || out_tag[3] !== 2'd2 || out_data[3] !== 32'd0) begin
         n_fail++; $display("FAIL route_p3: got %b/%0d/%h want 10/2/0", out_resp[3], out_tag[3], out_data[3]);
      end
      n_checks++; if (out_resp[2:0] !== 6'b0) begin n_fail++; $display("FAIL route_others: got %h want 0", out_resp[2:0]); end
      tick();
      n_checks++; if (out_resp[3] !== 2'b00) begin n_fail++; $display("FAIL route_pulse: got %b want 00", out_resp[3]); end
   endtask

   initial begin
      req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
      alu_bus.alu_ready = 1'b0; alu_bus.rsp_valid = 1'b0; alu_bus.rsp_resp = 2'b00;
      alu_bus.rsp_data = 32'd0; alu_bus.rsp_port = 2'd0; alu_bus.rsp_tag = 2'd0;
      test_reset();
      test_basic();
      test_rr();
      test_illegal();
      test_full_ovf();
      test_reset_mid();
      test_rsp_route();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/calc2_req_sched.md
Name: calc2_req_sched

Overview:
Request scheduler in front of a single shared calc2 ALU. It collects two-operand commands from four requester ports into per-port queues and arbitrates round-robin for the ALU through a valid/ready handshake. It routes ALU responses back to the originating port as one-cycle pulses. Illegal commands are answered locally without using the ALU.

Parameters:
NPORTS, 4, number of requester ports (fixed 4 for calc2; drives array sizes)
DW, 32, operand/result width
TW, 2, tag width
QDEPTH, 4, per-port request queue depth (power of 2, >=2)

Ports:
c_clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high
req_cmd_in  in  [NPORTS][4]  command; 0 = no request
req_data_in  in  [NPORTS][DW]  op1 in cmd cycle, op2 in next cycle
req_tag_in  in  [NPORTS][TW]  tag, sampled in cmd cycle
req_full  out  [NPORTS]  queue full; requester must not issue a cmd while high
ovf_err  out  [NPORTS]  sticky: cmd dropped because queue was full
out_resp  out  [NPORTS][2]  00 none, 01 ok, 10 error/overflow
out_data  out  [NPORTS][DW]  result, valid with out_resp!=0
out_tag  out  [NPORTS][TW]  tag of response
alu_valid  out  1  issue request valid
alu_ready  in  1  ALU accepts issue
alu_cmd  out  4  command
alu_op1  out  DW  operand 1
alu_op2  out  DW  operand 2
alu_port  out  2  originating port
alu_tag  out  TW  originating tag
rsp_valid  in  1  ALU response valid (one cycle)
rsp_resp  in  2  response code
rsp_data  in  DW  result
rsp_port  in  2  destination port
rsp_tag  in  TW  destination tag

Behaviour:
- Reset (asynchronous): all outputs 0; queues empty; collectors IDLE; RR pointer = port 0; ovf_err cleared.
- Collector FSM, per port: IDLE --cmd!=0--> OP2. Latch cmd, data->op1, tag. OP2 (unconditional, next cycle) latches data->op2, pushes {cmd,op1,op2,tag}, returns to IDLE. A cmd!=0 seen in OP2 is treated as op2 data, not as a new command.
- Back-to-back: a new cmd is legal in the cycle after OP2.
- Full handling: req_full is registered, high when count==QDEPTH, or when count==QDEPTH-1 and a push is pending. If a push finds the queue full, the entry is dropped and ovf_err[p] is set sticky.
- Legal commands: 1 add, 2 sub, 5 shl, 6 shr. Any other nonzero cmd is illegal.
- Illegal head: popped without an ALU issue. Produces a local response: resp=10, data=0, own tag.
- Arbitration: only when no issue is held. Candidates are ports whose queue is non-empty with a legal head. Search starts at the RR pointer. The winner's head is loaded into the registered alu_* outputs, alu_valid=1.
- Issue hold: alu_* stay stable while alu_valid && !alu_ready.
- On handshake (alu_valid && alu_ready):
  - pop the winner's queue;
  - RR pointer = winner+1 mod 4;
  - alu_valid drops the next cycle unless a new grant is made in that same cycle, so back-to-back issue is possible.
  - Issue latency: push to alu_valid is at minimum 1 cycle.
- Response routing:
  - rsp_valid at cycle t -> out_resp/out_data/out_tag[rsp_port] driven at t+1 for exactly one cycle. All other ports show 0 that cycle.
  - The scheduler holds no per-response state.
- Collision: a local illegal response and an ALU response for the same port in the same cycle -> the ALU response wins. The illegal head stays queued and is retried the next cycle.
- Reset mid-operation: the held issue is abandoned and queued commands are lost. ALU responses arriving after reset deassert are routed normally.
- Queue pointers wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits.

Decomposition:
- Package calc2_sched_pkg:
  - cmd constants CMD_ADD=4'h1, CMD_SUB=4'h2, CMD_SHL=4'h5, CMD_SHR=4'h6;
  - resp constants RESP_NONE, RESP_OK, RESP_ERR;
  - typedef req_entry_t {cmd, op1, op2, tag};
  - function is_legal_cmd.
- Sub-module calc2_req_queue: one per port, combining the collector FSM, the FIFO and the full logic.
- The top level holds the RR arbiter, the issue register and response routing.

Test Plan:
- Port 0: cmd=1, op1=5, op2=3, tag=2; alu_ready=1; ALU returns rsp_port=0, resp=01, data=8 -> alu_valid with cmd=1, op1=5, op2=3, port=0, tag=2. The next cycle after rsp_valid: out_resp[0]=01, out_data[0]=8, out_tag[0]=2, single cycle.
- All four ports issue cmd=2 in the same cycle; alu_ready=1 -> alu_port sequence 0,1,2,3 on consecutive cycles. A second round started with pointer=1 grants 1,2,3,0.
- Port 2: cmd=4'h9, tag=1 -> no alu_valid; out_resp[2]=10, out_data[2]=0, out_tag[2]=1. A concurrent rsp for port 2 delays it one cycle.
- Port 1: 5 back-to-back cmds with alu_ready=0 -> req_full[1]=1 after the 4th. Forcing a 5th sets ovf_err[1]=1 sticky. alu_* stay stable for the entire ready-low period.
- reset asserted while alu_valid=1 and queues hold 3 entries -> all outputs 0 immediately; after release, port 3 cmd=5 is issued first, proving queues are empty.
- rsp_valid with rsp_port=3, resp=10, data=0 and no prior issue -> routed unchanged to out_resp[3]=10.
